// File: rtl/laser_cover_if.sv
// Point stream, circle centres and result signals exchanged between the
// LASER producer (master) and the coverage counter (slave).
interface laser_cover_if;
    logic [3:0] X;
    logic [3:0] Y;
    logic       IN_DONE;
    logic [3:0] C1X;
    logic [3:0] C1Y;
    logic [3:0] C2X;
    logic [3:0] C2Y;
    logic [5:0] COVER;
    logic       VALID;
    logic       ERR;

    modport master (
        output X, Y, IN_DONE, C1X, C1Y, C2X, C2Y,
        input  COVER, VALID, ERR
    );

    modport slave (
        input  X, Y, IN_DONE, C1X, C1Y, C2X, C2Y,
        output COVER, VALID, ERR
    );
endinterface

// File: rtl/laser_cover.sv
// Coverage counter: loads NPTS points, waits for the circle centres, then
// scans one stored point per cycle and reports how many lie within the
// inclusive radius of either circle. Result is held until the next reset.
module laser_cover #(
    parameter int unsigned NPTS = 40,
    parameter int unsigned R2   = 16
) (
    input  logic          CLK,
    input  logic          RST,
    laser_cover_if.slave  bus
);

    localparam int unsigned   IW     = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam logic [IW-1:0] LAST   = IW'(NPTS - 1);
    localparam logic [8:0]    R2_W   = 9'(R2);

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        SCAN,
        REPORT
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q,   cnt_d;
    logic [IW-1:0] idx_q,   idx_d;
    logic [5:0]    acc_q,   acc_d;
    logic [5:0]    cover_q, cover_d;
    logic          valid_q, valid_d;
    logic          err_q,   err_d;
    logic [3:0]    c1x_q, c1x_d, c1y_q, c1y_d;
    logic [3:0]    c2x_q, c2x_d, c2y_q, c2y_d;

    // Point memory: {X,Y} per entry, fully rewritten by every LOAD phase.
    logic [7:0]    mem [NPTS];

    logic [7:0]    pt;
    logic [8:0]    d1;
    logic [8:0]    d2;
    logic          covered;

    // Squared Euclidean distance; 5-bit signed deltas, 9-bit result (max 450).
    function automatic logic [8:0] dist2(input logic [3:0] px, input logic [3:0] py,
                                         input logic [3:0] cx, input logic [3:0] cy);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic signed [9:0] sx;
        logic signed [9:0] sy;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        sx = 10'(dx) * 10'(dx);
        sy = 10'(dy) * 10'(dy);
        return sx[8:0] + sy[8:0];
    endfunction

    // Coverage test of the point currently addressed by the scan index.
    always_comb begin
        pt      = mem[idx_q];
        d1      = dist2(pt[7:4], pt[3:0], c1x_q, c1y_q);
        d2      = dist2(pt[7:4], pt[3:0], c2x_q, c2y_q);
        covered = (d1 <= R2_W) || (d2 <= R2_W);
    end

    // Next-state and datapath updates for the LOAD/WAIT/SCAN/REPORT sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cover_d = '0;
        valid_d = valid_q;
        err_d   = err_q;
        c1x_d   = c1x_q;
        c1y_d   = c1y_q;
        c2x_d   = c2x_q;
        c2y_d   = c2y_q;

        unique case (state_q)
            LOAD: begin
                if (bus.IN_DONE) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (bus.IN_DONE) begin
                    c1x_d   = bus.C1X;
                    c1y_d   = bus.C1Y;
                    c2x_d   = bus.C2X;
                    c2y_d   = bus.C2Y;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (covered) begin
                    acc_d = acc_q + 6'd1;
                end
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            REPORT: begin
                // Outputs are registered, so VALID rises one edge after
                // the final point has been accumulated.
                cover_d = acc_q;
                valid_d = 1'b1;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            cover_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            c1x_q   <= '0;
            c1y_q   <= '0;
            c2x_q   <= '0;
            c2y_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            cover_q <= cover_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            c1x_q   <= c1x_d;
            c1y_q   <= c1y_d;
            c2x_q   <= c2x_d;
            c2y_q   <= c2y_d;
        end
    end

    // Point capture during LOAD; no reset needed since every entry is rewritten.
    always_ff @(posedge CLK) begin
        if (!RST && state_q == LOAD) begin
            mem[cnt_q] <= {bus.X, bus.Y};
        end
    end

    assign bus.COVER = cover_q;
    assign bus.VALID = valid_q;
    assign bus.ERR   = err_q;

endmodule
